// File: rtl/serial_word_deframer_pkg.sv
// Shared types and line-level constants for the serial word deframer.
// Covers the FSM state encoding and the start/stop bit values.
package deframer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2
   } state_t;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_word_deframer_if.sv
// Valid/ready word output channel between the deframer and its downstream consumer.
// The deframer side uses the master modport; the consumer uses slave.
interface serial_word_deframer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;

   modport master (
      output word_out,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_out,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/serial_word_deframer_sipo.sv
// Serial-in parallel-out shift register with shift enable and synchronous clear.
// The MSB_FIRST parameter sets which end of the register the first shifted bit reaches.
module sipo_shreg
   import deframer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   // After exactly WIDTH shifts, the first bit has reached the far end of the register.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (shift_en) begin
         if (MSB_FIRST) begin
            q <= {q[WIDTH-2:0], din};
         end else begin
            q <= {din, q[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/serial_word_deframer.sv
// Rebuilds start/payload/stop framed words from a strobed serial bit stream.
// Completed words go into a valid/ready holding register, with framing and overrun flags.
module serial_word_deframer
   import deframer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_in,
   input  logic                   bit_en,
   input  logic                   clr_status,
   serial_word_deframer_if.master out_if,
   output logic                   framing_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    bit_cnt;
   logic             start_det;
   logic             shift_en;
   logic             good_stop;
   logic             bad_stop;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] word_q;
   logic             valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (bit_en) begin
         case (state)
            IDLE:    if (data_in == START_BIT) next_state = SHIFT;
            SHIFT:   if (bit_cnt == LAST_CNT) next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      start_det = bit_en && (state == IDLE) && (data_in == START_BIT);
      shift_en  = bit_en && (state == SHIFT);
      good_stop = bit_en && (state == STOP) && (data_in == STOP_BIT);
      bad_stop  = bit_en && (state == STOP) && (data_in != STOP_BIT);
   end

   // The counter moves only on strobes and tops out at WIDTH on the last payload bit.
   always_ff @(posedge clk) begin
      if (rst || start_det) begin
         bit_cnt <= '0;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + 1'b1;
      end else if (bit_en && (state == STOP)) begin
         bit_cnt <= '0;
      end
   end

   sipo_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sipo (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_det),
      .shift_en (shift_en),
      .din      (data_in),
      .q        (shreg_q)
   );

   // A new word may load only when the register is empty or emptying on this same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q      <= '0;
         valid_q     <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         framing_err <= bad_stop;
         if (good_stop && (!valid_q || out_if.word_ready)) begin
            word_q  <= shreg_q;
            valid_q <= 1'b1;
         end else if (valid_q && out_if.word_ready) begin
            valid_q <= 1'b0;
         end
         if (good_stop && valid_q && !out_if.word_ready) begin
            overrun <= 1'b1;
         end else if (clr_status) begin
            overrun <= 1'b0;
         end
      end
   end

   assign out_if.word_out   = word_q;
   assign out_if.word_valid = valid_q;

endmodule

// File: tb/tb_serial_word_deframer.sv
// Self-checking bench for serial_word_deframer: a frame table, hand-written corner sequences,
// and a scoreboard of words checked whenever a valid/ready transfer takes place.
module tb_serial_word_deframer;

   logic clk;
   logic rst;
   logic data_in;
   logic bit_en;
   logic clr_status;
   logic framing_err;
   logic overrun;
   logic busy;
   logic l_framing_err;
   logic l_overrun;
   logic l_busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb[$];

   serial_word_deframer_if #(.WIDTH(8)) m_if ();
   serial_word_deframer_if #(.WIDTH(8)) l_if ();

   assign l_if.word_ready = 1'b1;

   serial_word_deframer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .bit_en      (bit_en),
      .clr_status  (clr_status),
      .out_if      (m_if),
      .framing_err (framing_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   serial_word_deframer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .bit_en      (bit_en),
      .clr_status  (clr_status),
      .out_if      (l_if),
      .framing_err (l_framing_err),
      .overrun     (l_overrun),
      .busy        (l_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      logic [7:0] payload;
      logic       stop_bit;
      logic       exp_valid;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7 - i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic strobe(input logic b);
      data_in = b;
      bit_en  = 1'b1;
      tick();
      bit_en  = 1'b0;
   endtask

   task automatic gap();
      repeat (3) tick();
   endtask

   // Start bit plus payload, first transmitted bit is payload[7]; stop bit is left to the caller.
   task automatic send_frame(input logic [7:0] p);
      strobe(1'b1);
      gap();
      for (int i = 7; i >= 0; i--) begin
         strobe(p[i]);
         gap();
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      strobe(1'b1);
      checkOutput({v.name, "_busy_start"}, 32'(busy), 32'd1);
      gap();
      for (int i = 7; i >= 0; i--) begin
         strobe(v.payload[i]);
         gap();
      end
      if (v.exp_valid) sb.push_back(v.payload);
      strobe(v.stop_bit);
      checkOutput({v.name, "_valid"}, 32'(m_if.word_valid), 32'(v.exp_valid));
      if (v.exp_valid) checkOutput({v.name, "_word"}, 32'(m_if.word_out), 32'(v.payload));
      checkOutput({v.name, "_ferr"}, 32'(framing_err), 32'(v.exp_ferr));
      checkOutput({v.name, "_overrun"}, 32'(overrun), 32'd0);
      checkOutput({v.name, "_busy_end"}, 32'(busy), 32'd0);
      tick();
      checkOutput({v.name, "_ferr_gone"}, 32'(framing_err), 32'd0);
      checkOutput({v.name, "_valid_gone"}, 32'(m_if.word_valid), 32'd0);
      gap();
   endtask

   // Transfers are judged mid-cycle, after the bench has settled its inputs for the next edge.
   initial begin
      logic [7:0] exp_word;
      forever begin
         @(negedge clk);
         #3;
         if (m_if.word_valid && m_if.word_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_unexpected: got %0h expected none", m_if.word_out);
            end else begin
               exp_word = sb.pop_front();
               checkOutput("sb_word", 32'(m_if.word_out), 32'(exp_word));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{"good_a5",  8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{"bad_3c",   8'h3C, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"good_3c",  8'h3C, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{"good_00",  8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{"good_ff",  8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{"bad_81",   8'h81, 1'b1, 1'b0, 1'b1};

      rst             = 1'b1;
      data_in         = 1'b0;
      bit_en          = 1'b1;
      clr_status      = 1'b0;
      m_if.word_ready = 1'b0;
      @(negedge clk);

      $display("[TB] reset with toggling line");
      data_in = 1'b1;
      tick();
      data_in = 1'b0;
      tick();
      checkOutput("rst_valid", 32'(m_if.word_valid), 32'd0);
      checkOutput("rst_word", 32'(m_if.word_out), 32'd0);
      checkOutput("rst_ferr", 32'(framing_err), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst    = 1'b0;
      bit_en = 1'b0;
      strobe(1'b0);
      checkOutput("idle_line_busy", 32'(busy), 32'd0);
      gap();

      $display("[TB] frame table");
      m_if.word_ready = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      $display("[TB] backpressure");
      m_if.word_ready = 1'b0;
      send_frame(8'h11);
      sb.push_back(8'h11);
      strobe(1'b0);
      checkOutput("bp_valid1", 32'(m_if.word_valid), 32'd1);
      checkOutput("bp_word1", 32'(m_if.word_out), 32'h11);
      checkOutput("bp_overrun1", 32'(overrun), 32'd0);
      gap();
      send_frame(8'h22);
      strobe(1'b0);
      checkOutput("bp_word2", 32'(m_if.word_out), 32'h11);
      checkOutput("bp_overrun2", 32'(overrun), 32'd1);
      gap();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      checkOutput("bp_clr", 32'(overrun), 32'd0);
      checkOutput("bp_held", 32'(m_if.word_out), 32'h11);
      m_if.word_ready = 1'b1;
      tick();
      checkOutput("bp_drained", 32'(m_if.word_valid), 32'd0);
      m_if.word_ready = 1'b0;
      gap();

      $display("[TB] accept and load on the same edge");
      send_frame(8'hC3);
      sb.push_back(8'hC3);
      strobe(1'b0);
      checkOutput("sim_c3", 32'(m_if.word_out), 32'hC3);
      gap();
      send_frame(8'h5A);
      m_if.word_ready = 1'b1;
      sb.push_back(8'h5A);
      strobe(1'b0);
      checkOutput("sim_valid", 32'(m_if.word_valid), 32'd1);
      checkOutput("sim_word", 32'(m_if.word_out), 32'h5A);
      checkOutput("sim_overrun", 32'(overrun), 32'd0);
      tick();
      checkOutput("sim_drained", 32'(m_if.word_valid), 32'd0);
      gap();

      $display("[TB] reset mid-frame");
      strobe(1'b1);
      gap();
      for (int i = 0; i < 4; i++) begin
         strobe(1'b1);
         gap();
      end
      checkOutput("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_valid", 32'(m_if.word_valid), 32'd0);
      gap();
      send_frame(8'hF0);
      sb.push_back(8'hF0);
      strobe(1'b0);
      checkOutput("mid_word", 32'(m_if.word_out), 32'hF0);
      checkOutput("lsb_f0_valid", 32'(l_if.word_valid), 32'd1);
      checkOutput("lsb_f0_word", 32'(l_if.word_out), 32'(rev8(8'hF0)));
      gap();
      send_frame(8'hA5);
      sb.push_back(8'hA5);
      strobe(1'b0);
      checkOutput("lsb_a5_word", 32'(l_if.word_out), 32'(rev8(8'hA5)));
      checkOutput("msb_a5_word", 32'(m_if.word_out), 32'hA5);
      gap();

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
